adder_response_checker: RTL and testbench
=========================================

Name: adder_response_checker

Overview:
- Synthesizable response checker: the receiving end of the adder stimulus flow.
- A stimulus source drives operand pairs into an adder DUT and, in parallel, into this block.
- The block aligns each pair with the DUT's sum/carry, compares against the golden result a+b, and counts checks and errors.
- Captures the first failing vector and reports pass/fail when the programmed number of vectors has been checked.
- WIDTH=1, LATENCY=0 covers the combinational half adder.

Parameters:
- WIDTH, 1, operand width in bits.
- LATENCY, 0, DUT pipeline delay in cycles from operands to sum/carry; legal range 0..4.
- CNT_W, 16, width of the vector, check and error counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse that arms a checking run.
- num_vectors  input  CNT_W  number of comparisons for this run; sampled on start.
- in_valid  input  1  a/b valid this cycle, i.e. applied to the DUT.
- a  input  WIDTH  operand A applied to the DUT.
- b  input  WIDTH  operand B applied to the DUT.
- sum  input  WIDTH  DUT sum output.
- carry  input  1  DUT carry output.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid when done=1; equals (err_count==0).
- check_count  output  CNT_W  comparisons performed this run.
- err_count  output  CNT_W  mismatches this run; saturates at all-ones.
- first_err_valid  output  1  at least one mismatch captured.
- first_err_idx  output  CNT_W  zero-based index of the first mismatching comparison.
- first_err_a  output  WIDTH  operand A of the first mismatch.
- first_err_b  output  WIDTH  operand B of the first mismatch.
- first_err_obs  output  WIDTH+1  observed {carry,sum} of the first mismatch.

Behaviour:
- Reset: state IDLE; every output 0; delay-line valid bits cleared; latched target 0.
- Reset mid-run: same as reset; any in-flight operands are discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start:
  - num_vectors != 0: latch the target, clear all counters and first_err_* fields, enter RUN next cycle.
  - num_vectors == 0: enter DONE next cycle with pass=1 and all counters 0.
- start while in RUN: ignored.
- in_valid outside RUN: ignored; nothing enters the delay line.
- Delay line (RUN):
  - LATENCY stages of {valid,a,b}.
  - LATENCY=0: compare in the same cycle in_valid is high.
  - LATENCY=N: compare N cycles after in_valid is accepted, against that cycle's sum/carry.
  - Gaps in in_valid are allowed; bubbles propagate without triggering a compare.
- Compare:
  - expected = zero-extended a + zero-extended b, WIDTH+1 bits.
  - observed = {carry,sum}.
  - Each compare increments check_count.
  - On mismatch, err_count increments (saturating).
  - If first_err_valid=0 on a mismatch: capture idx = pre-increment check_count, plus a, b and observed; set first_err_valid.
- Termination:
  - The compare that makes check_count equal the target moves the FSM to DONE on the next edge.
  - Later in_valid or delayed entries are ignored and the delay line is flushed.
  - Counters hold their values in DONE.
- DONE persists until start or rst.

Test Plan:
- WIDTH=1, LATENCY=0, num_vectors=4; vectors (0,0),(0,1),(1,0),(1,1) driven with correct DUT outputs -> done=1 one cycle after the 4th vector, pass=1, check_count=4, err_count=0, first_err_valid=0.
- Same run with the DUT forced to sum=1, carry=1 on vector (1,1) -> err_count=1, first_err_idx=3, first_err_a=1, first_err_b=1, first_err_obs=2'b11, pass=0.
- LATENCY=2, WIDTH=4; vectors (15,1),(7,8),(0,0) with one idle cycle between the first two, DUT outputs delayed 2 cycles -> expected values 16, 15, 0 match, pass=1, check_count=3.
- start with num_vectors=0 -> done=1 on the next cycle, pass=1, counters 0; in_valid pulses while in DONE leave check_count=0.
- num_vectors=4, rst asserted after 2 vectors -> next cycle busy=0, check_count=0, err_count=0; restart with 4 correct vectors passes.
- Second start pulse mid-run plus in_valid before the first start -> target unchanged, pre-start vectors not counted, run completes after exactly num_vectors compares.

Source files
------------

// File: rtl/adder_response_checker.sv
// Response checker for an adder DUT: aligns each operand pair with the DUT's
// {carry,sum} after LATENCY cycles, compares it against a+b, and counts checks
// and errors. It also captures the first failing vector and reports pass/fail.
// Ports: clk/rst (sync, active-high); start/num_vectors arm a run;
//        in_valid/a/b are the operands applied to the DUT; sum/carry are the DUT outputs;
//        busy/done/pass give run status; check_count/err_count are the counters;
//        first_err_* hold the first mismatching vector.
module adder_response_checker #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH:0]   first_err_obs
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target;

  // Operands as they line up with the DUT output in the current cycle.
  logic             cmp_vld;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic [WIDTH:0]   expected, observed;
  logic             mismatch;
  logic [CNT_W-1:0] check_inc;

  generate
    if (LATENCY == 0) begin : g_nodelay
      assign cmp_vld = (state == RUN) && in_valid;
      assign cmp_a   = a;
      assign cmp_b   = b;
    end else begin : g_delay
      logic [LATENCY-1:0] dl_vld;
      logic [WIDTH-1:0]   dl_a [LATENCY];
      logic [WIDTH-1:0]   dl_b [LATENCY];

      // Valid bits only advance in RUN; leaving RUN (or never entering it)
      // flushes anything still in flight.
      always_ff @(posedge clk) begin
        if (rst || state != RUN) begin
          dl_vld <= '0;
        end else begin
          dl_vld[0] <= in_valid;
          for (int i = 1; i < LATENCY; i++) dl_vld[i] <= dl_vld[i-1];
        end
      end

      // Operand payload is qualified by dl_vld, so it needs no reset.
      always_ff @(posedge clk) begin
        dl_a[0] <= a;
        dl_b[0] <= b;
        for (int i = 1; i < LATENCY; i++) begin
          dl_a[i] <= dl_a[i-1];
          dl_b[i] <= dl_b[i-1];
        end
      end

      assign cmp_vld = (state == RUN) && dl_vld[LATENCY-1];
      assign cmp_a   = dl_a[LATENCY-1];
      assign cmp_b   = dl_b[LATENCY-1];
    end
  endgenerate

  assign expected  = {1'b0, cmp_a} + {1'b0, cmp_b};
  assign observed  = {carry, sum};
  assign mismatch  = (expected != observed);
  assign check_inc = check_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (num_vectors == '0) ? DONE : RUN;
      RUN:        if (cmp_vld && check_inc == target) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target          <= '0;
      check_count     <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_obs   <= '0;
    end else if (start && state != RUN) begin
      target          <= num_vectors;
      check_count     <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_obs   <= '0;
    end else if (cmp_vld) begin
      check_count <= check_inc;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= check_count;
          first_err_a     <= cmp_a;
          first_err_b     <= cmp_b;
          first_err_obs   <= observed;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_adder_response_checker.sv
module tb_adder_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance u0: WIDTH=1, LATENCY=0 (half adder)
  logic        start0 = 0, iv0 = 0, c0 = 0;
  logic [15:0] nv0 = 0;
  logic        a0 = 0, b0 = 0, s0 = 0;
  logic        busy0, done0, pass0, fev0, fea0, feb0;
  logic [15:0] cc0, ec0, fei0;
  logic [1:0]  feo0;

  adder_response_checker #(.WIDTH(1), .LATENCY(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start0), .num_vectors(nv0), .in_valid(iv0),
    .a(a0), .b(b0), .sum(s0), .carry(c0), .busy(busy0), .done(done0),
    .pass(pass0), .check_count(cc0), .err_count(ec0), .first_err_valid(fev0),
    .first_err_idx(fei0), .first_err_a(fea0), .first_err_b(feb0),
    .first_err_obs(feo0)
  );

  // Instance u2: WIDTH=4, LATENCY=2
  logic        start2 = 0, iv2 = 0, c2 = 0;
  logic [15:0] nv2 = 0;
  logic [3:0]  a2 = 0, b2 = 0, s2 = 0;
  logic        busy2, done2, pass2, fev2;
  logic [3:0]  fea2, feb2;
  logic [15:0] cc2, ec2, fei2;
  logic [4:0]  feo2;

  adder_response_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start2), .num_vectors(nv2), .in_valid(iv2),
    .a(a2), .b(b2), .sum(s2), .carry(c2), .busy(busy2), .done(done2),
    .pass(pass2), .check_count(cc2), .err_count(ec2), .first_err_valid(fev2),
    .first_err_idx(fei2), .first_err_a(fea2), .first_err_b(feb2),
    .first_err_obs(feo2)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One correct half-adder vector on u0.
  task automatic vec0(input logic va, input logic vb);
    iv0 = 1; a0 = va; b0 = vb; s0 = va ^ vb; c0 = va & vb;
    cyc();
    iv0 = 0;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_cc", cc0, 0);
    chk("rst_ec", ec0, 0);
    chk("rst_fev", fev0, 0);
    chk("rst_busy2", busy2, 0);
    rst = 0;

    // in_valid while IDLE must not be counted
    vec0(1, 1);
    chk("idle_iv_cc", cc0, 0);
    chk("idle_iv_busy", busy0, 0);

    // Run 1: four correct vectors
    start0 = 1; nv0 = 4;
    cyc();
    start0 = 0;
    chk("r1_busy", busy0, 1);
    chk("r1_cc0", cc0, 0);
    vec0(0, 0); vec0(0, 1); vec0(1, 0);
    chk("r1_notdone", done0, 0);
    vec0(1, 1);
    chk("r1_done", done0, 1);
    chk("r1_pass", pass0, 1);
    chk("r1_cc", cc0, 4);
    chk("r1_ec", ec0, 0);
    chk("r1_fev", fev0, 0);

    // Run 2: (1,1) answered with sum=1,carry=1
    start0 = 1; nv0 = 4;
    cyc();
    start0 = 0;
    chk("r2_cc_cleared", cc0, 0);
    vec0(0, 0); vec0(0, 1); vec0(1, 0);
    iv0 = 1; a0 = 1; b0 = 1; s0 = 1; c0 = 1;
    cyc();
    iv0 = 0;
    chk("r2_done", done0, 1);
    chk("r2_pass", pass0, 0);
    chk("r2_ec", ec0, 1);
    chk("r2_fev", fev0, 1);
    chk("r2_fei", fei0, 3);
    chk("r2_fea", fea0, 1);
    chk("r2_feb", feb0, 1);
    chk("r2_feo", feo0, 2'b11);

    // Zero-length run, then in_valid while DONE
    start0 = 1; nv0 = 0;
    cyc();
    start0 = 0;
    chk("z_done", done0, 1);
    chk("z_pass", pass0, 1);
    chk("z_cc", cc0, 0);
    chk("z_ec", ec0, 0);
    chk("z_fev", fev0, 0);
    vec0(1, 0); vec0(0, 1);
    chk("z_iv_cc", cc0, 0);
    chk("z_still_done", done0, 1);

    // Reset mid-run
    start0 = 1; nv0 = 4;
    cyc();
    start0 = 0;
    vec0(0, 1);
    iv0 = 1; a0 = 1; b0 = 1; s0 = 1; c0 = 1;   // erroneous second vector
    cyc();
    chk("mr_ec_before", ec0, 1);
    rst = 1; iv0 = 1;
    cyc();
    rst = 0; iv0 = 0;
    chk("mr_busy", busy0, 0);
    chk("mr_done", done0, 0);
    chk("mr_cc", cc0, 0);
    chk("mr_ec", ec0, 0);
    chk("mr_fev", fev0, 0);
    start0 = 1; nv0 = 4;
    cyc();
    start0 = 0;
    vec0(1, 1); vec0(1, 0); vec0(0, 1); vec0(0, 0);
    chk("mr2_done", done0, 1);
    chk("mr2_pass", pass0, 1);
    chk("mr2_cc", cc0, 4);

    // Restart ignored mid-run; bubbles at LATENCY=0
    start0 = 1; nv0 = 3;
    cyc();
    start0 = 0;
    vec0(1, 0);
    cyc();                                      // bubble
    chk("sr_cc1", cc0, 1);
    start0 = 1; nv0 = 10;
    vec0(1, 1);
    start0 = 0;
    chk("sr_busy", busy0, 1);
    chk("sr_cc2", cc0, 2);
    vec0(0, 1);
    chk("sr_done", done0, 1);
    chk("sr_cc3", cc0, 3);
    chk("sr_pass", pass0, 1);
    vec0(1, 1);
    chk("sr_hold_cc", cc0, 3);

    // LATENCY=2, WIDTH=4: (15,1), gap, (7,8), (0,0)
    start2 = 1; nv2 = 3;
    cyc();
    start2 = 0;
    chk("l2_busy", busy2, 1);
    iv2 = 1; a2 = 15; b2 = 1; s2 = 0;  c2 = 0;  cyc();
    iv2 = 0; a2 = 0;  b2 = 0; s2 = 9;  c2 = 1;  cyc();   // DUT still in flight
    iv2 = 1; a2 = 7;  b2 = 8; s2 = 0;  c2 = 1;  cyc();   // 16 for (15,1)
    chk("l2_cc1", cc2, 1);
    iv2 = 1; a2 = 0;  b2 = 0; s2 = 5;  c2 = 1;  cyc();   // bubble slot, garbage
    chk("l2_cc_bubble", cc2, 1);
    iv2 = 0;          s2 = 15; c2 = 0;  cyc();           // 15 for (7,8)
    chk("l2_cc2", cc2, 2);
    chk("l2_busy2", busy2, 1);
    s2 = 0; c2 = 0; cyc();                               // 0 for (0,0)
    chk("l2_done", done2, 1);
    chk("l2_pass", pass2, 1);
    chk("l2_cc3", cc2, 3);
    chk("l2_ec", ec2, 0);
    s2 = 3; c2 = 1; cyc(); cyc();
    chk("l2_hold_cc", cc2, 3);
    chk("l2_hold_ec", ec2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
